// File: rtl/mul_accum_border_if.sv
// Bus bundle for mul_accum_border: window control, bitstream input,
// incoming partial-sum handshake and outgoing partial-sum handshake.
// Signal directions are named from the accumulator's point of view.
interface mul_accum_border_if #(
  parameter int unsigned CYCLE_BITS = 8,
  parameter int unsigned ACC_WIDTH  = 16
);
  logic                  i_start;
  logic [CYCLE_BITS-1:0] i_cycles;
  logic                  i_sign;
  logic                  i_bit;
  logic [ACC_WIDTH-1:0]  i_psum;
  logic                  i_psum_valid;
  logic                  o_psum_ready;
  logic                  o_busy;
  logic [ACC_WIDTH-1:0]  o_psum;
  logic                  o_valid;
  logic                  i_ready;

  // Upstream/downstream side that drives the accumulator
  modport master (
    output i_start, i_cycles, i_sign, i_bit, i_psum, i_psum_valid, i_ready,
    input  o_psum_ready, o_busy, o_psum, o_valid
  );

  // Accumulator side
  modport slave (
    input  i_start, i_cycles, i_sign, i_bit, i_psum, i_psum_valid, i_ready,
    output o_psum_ready, o_busy, o_psum, o_valid
  );
endinterface

// File: rtl/mul_accum_border.sv
// mul_accum_border: counts ones of the border multiplier's product bitstream
// over a programmable window, applies the product sign and merges the count
// into the neighbouring PE's partial sum, handing the result off on a
// valid/ready output.
// Optional feature macro: MUL_ACCUM_SAT_EN (saturating merge; wraps otherwise).
module mul_accum_border #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CYCLE_BITS = 8,
  parameter int unsigned ACC_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  mul_accum_border_if.slave      bus
);

  localparam int unsigned CNT_W = CYCLE_BITS + 1;
`ifdef MUL_ACCUM_SAT_EN
  localparam int unsigned SUM_W = ACC_WIDTH + 1;
`else
  localparam int unsigned SUM_W = ACC_WIDTH;
`endif

  // Elaboration-time guard on the parameter set
  if (WIDTH < 2 || ACC_WIDTH < CYCLE_BITS + 2) begin : g_param_check
    $error("mul_accum_border: need WIDTH >= 2 and ACC_WIDTH >= CYCLE_BITS+2");
  end

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_MERGE, S_HOLD} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CYCLE_BITS-1:0] r_rem;
  logic                  r_sign;
  logic                  r_busy;
  logic                  r_valid;
  logic [ACC_WIDTH-1:0]  r_psum;

  logic                  w_psum_ready;
  logic [SUM_W-1:0]      w_psum_ext;
  logic [SUM_W-1:0]      w_cnt_ext;
  logic [SUM_W-1:0]      w_sum;
  logic [ACC_WIDTH-1:0]  w_result;

  // Partial sum is consumed in the same cycle it is seen in MERGE
  assign w_psum_ready = (r_state == S_MERGE) && bus.i_psum_valid;

  // Signed merge of the partial sum with the sign-applied count
  assign w_psum_ext = SUM_W'($signed(bus.i_psum));
  assign w_cnt_ext  = SUM_W'(r_cnt);
  assign w_sum      = r_sign ? (w_psum_ext - w_cnt_ext) : (w_psum_ext + w_cnt_ext);

`ifdef MUL_ACCUM_SAT_EN
  // Clamp to the signed range when the extra guard bit disagrees with the MSB
  always_comb begin
    w_result = w_sum[ACC_WIDTH-1:0];
    if (w_sum[SUM_W-1] != w_sum[SUM_W-2]) begin
      w_result = w_sum[SUM_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  // Two's-complement wrap
  assign w_result = w_sum;
`endif

  // Window FSM: start, count bits, merge partial sum, hold result for handoff
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_sign  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_psum  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_cnt  <= CNT_W'(bus.i_bit);
            r_rem  <= bus.i_cycles - CYCLE_BITS'(1);
            r_sign <= bus.i_sign;
            r_busy <= 1'b1;
            r_state <= (bus.i_cycles == CYCLE_BITS'(1)) ? S_MERGE : S_COUNT;
          end
        end
        S_COUNT: begin
          r_cnt <= r_cnt + CNT_W'(bus.i_bit);
          r_rem <= r_rem - CYCLE_BITS'(1);
          if (r_rem == CYCLE_BITS'(1)) begin
            r_state <= S_MERGE;
          end
        end
        S_MERGE: begin
          if (bus.i_psum_valid) begin
            r_psum  <= w_result;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_psum_ready = w_psum_ready;
  assign bus.o_busy       = r_busy;
  assign bus.o_valid      = r_valid;
  assign bus.o_psum       = r_psum;

endmodule

// File: tb/tb_mul_accum_border.sv
// Self-checking bench for mul_accum_border. Cycle t is the clock period ending
// at rising edge t; inputs for cycle t are driven on the preceding falling
// edge and outputs are sampled 1 time unit later.
module tb_mul_accum_border;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   bits_q [256];

  always #5 clk = ~clk;

  mul_accum_border_if #(.CYCLE_BITS(8), .ACC_WIDTH(16)) bus ();

  mul_accum_border #(.WIDTH(8), .CYCLE_BITS(8), .ACC_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: signed sum of partial sum and signed ones count, 16-bit result
  function automatic logic [15:0] model(input int cnt, input bit sgn, input logic [15:0] psum);
    int v;
    v = int'($signed(psum)) + (sgn ? -cnt : cnt);
`ifdef MUL_ACCUM_SAT_EN
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
`endif
    return 16'(v);
  endfunction

  function automatic int count_ones(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(bits_q[i]);
    return c;
  endfunction

  // Drives one complete window and reports what the DUT did
  task automatic run_window(input int ncyc, input bit sgn, input logic [15:0] psum,
                            input int pv_cyc, input int rdy_cyc, input int st1, input int st2,
                            output int rd_cyc, output int rd_pulses, output int v_cyc,
                            output logic [15:0] out, output bit stable, output bit busy1,
                            output bit busy_after, output bit valid_after, output bit timeout);
    int  n_eff;
    bit  done;
    bit  consumed;
    n_eff = (ncyc == 0) ? 256 : ncyc;
    rd_cyc = -1; rd_pulses = 0; v_cyc = -1; out = '0; stable = 1'b1;
    busy1 = 1'b0; done = 1'b0; consumed = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      bus.i_start      = (t == 0) || (t == st1) || (t == st2);
      bus.i_cycles     = (t == 0) ? 8'(ncyc) : 8'($urandom);
      bus.i_sign       = (t == 0) ? sgn : 1'($urandom);
      bus.i_bit        = (t < n_eff) ? bits_q[t] : 1'($urandom);
      bus.i_psum_valid = (t >= pv_cyc) && !consumed;
      bus.i_psum       = (t >= pv_cyc) ? psum : 16'($urandom);
      bus.i_ready      = (t >= rdy_cyc);
      #1;
      if (t == 1) busy1 = bus.o_busy;
      if (bus.o_psum_ready) begin
        rd_pulses++;
        if (rd_cyc < 0) rd_cyc = t;
        consumed = 1'b1;
      end
      if (bus.o_valid) begin
        if (v_cyc < 0) begin
          v_cyc = t;
          out   = bus.o_psum;
        end else if (bus.o_psum !== out) begin
          stable = 1'b0;
        end
        if (bus.i_ready) done = 1'b1;
      end
    end
    timeout = !done;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_psum_valid = 1'b0; bus.i_ready = 1'b0; bus.i_bit = 1'b0;
    #1;
    busy_after  = bus.o_busy;
    valid_after = bus.o_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_cycles = '0; bus.i_sign = 1'b0; bus.i_bit = 1'b1;
    bus.i_psum = 16'h1234; bus.i_psum_valid = 1'b1; bus.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
    n_tests++; if (bus.o_psum !== 16'h0) begin n_fail++; $display("FAIL reset_psum got=%h exp=0000", bus.o_psum); end
    n_tests++; if (bus.o_psum_ready !== 1'b0) begin n_fail++; $display("FAIL reset_psum_ready got=%b exp=0", bus.o_psum_ready); end
    rst = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (bus.o_psum_ready !== 1'b0) begin n_fail++; $display("FAIL idle_psum_ready got=%b exp=0", bus.o_psum_ready); end
    bus.i_psum_valid = 1'b0;
  endtask

  task automatic test_reset_mid_window;
    int rd, rp, vc; logic [15:0] o; bit st, b1, ba, va, to;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_cycles = 8'd100; bus.i_sign = 1'b0; bus.i_bit = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      bus.i_start = 1'b0; bus.i_bit = 1'($urandom);
      if (t == 40) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; #1;
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bus.o_busy); end
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", bus.o_valid); end
    for (int i = 0; i < 4; i++) bits_q[i] = 1'b1;
    run_window(4, 1'b0, 16'h0000, 0, 0, -1, -1, rd, rp, vc, o, st, b1, ba, va, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL midrst_timeout got=no_handshake exp=handshake"); end
    n_tests++; if (o !== 16'd4) begin n_fail++; $display("FAIL midrst_after_psum got=%h exp=0004", o); end
  endtask

  task automatic test_basic;
    int rd, rp, vc; logic [15:0] o; bit st, b1, ba, va, to;
    bit pat [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) bits_q[i] = pat[i];
    run_window(8, 1'b0, 16'd10, 0, 0, -1, -1, rd, rp, vc, o, st, b1, ba, va, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout got=no_handshake exp=handshake"); end
    n_tests++; if (rd != 8) begin n_fail++; $display("FAIL basic_ready_cycle got=%0d exp=8", rd); end
    n_tests++; if (rp != 1) begin n_fail++; $display("FAIL basic_ready_pulses got=%0d exp=1", rp); end
    n_tests++; if (vc != 9) begin n_fail++; $display("FAIL basic_valid_cycle got=%0d exp=9", vc); end
    n_tests++; if (o !== 16'd14) begin n_fail++; $display("FAIL basic_psum got=%h exp=000e", o); end
    n_tests++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got=%b exp=1", b1); end
    n_tests++; if (ba !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall got=%b exp=0", ba); end
    n_tests++; if (va !== 1'b0) begin n_fail++; $display("FAIL basic_valid_fall got=%b exp=0", va); end
  endtask

  task automatic test_neg_n0;
    int rd, rp, vc; logic [15:0] o; bit st, b1, ba, va, to;
    for (int i = 0; i < 256; i++) bits_q[i] = 1'b1;
    run_window(0, 1'b1, 16'd5, 0, 0, -1, -1, rd, rp, vc, o, st, b1, ba, va, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL n0_timeout got=no_handshake exp=handshake"); end
    n_tests++; if (rd != 256) begin n_fail++; $display("FAIL n0_ready_cycle got=%0d exp=256", rd); end
    n_tests++; if (vc != 257) begin n_fail++; $display("FAIL n0_valid_cycle got=%0d exp=257", vc); end
    n_tests++; if (o !== 16'hFF05) begin n_fail++; $display("FAIL n0_psum got=%h exp=ff05", o); end
  endtask

  task automatic test_backpressure;
    int rd, rp, vc; logic [15:0] o; bit st, b1, ba, va, to;
    logic [15:0] ps;
    bit sg;
    for (int i = 0; i < 5; i++) bits_q[i] = 1'($urandom);
    ps = 16'($urandom); sg = 1'($urandom);
    // HOLD from cycle 6, i_ready high from 11; extra starts at 8 and at the handshake
    run_window(5, sg, ps, 0, 11, 8, 11, rd, rp, vc, o, st, b1, ba, va, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL bp_timeout got=no_handshake exp=handshake"); end
    n_tests++; if (vc != 6) begin n_fail++; $display("FAIL bp_valid_cycle got=%0d exp=6", vc); end
    n_tests++; if (o !== model(count_ones(5), sg, ps)) begin n_fail++; $display("FAIL bp_psum got=%h exp=%h", o, model(count_ones(5), sg, ps)); end
    n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable got=changed exp=stable"); end
    n_tests++; if (ba !== 1'b0) begin n_fail++; $display("FAIL bp_start_ignored_busy got=%b exp=0", ba); end
    n_tests++; if (va !== 1'b0) begin n_fail++; $display("FAIL bp_valid_fall got=%b exp=0", va); end
  endtask

  task automatic test_late_psum;
    int rd, rp, vc; logic [15:0] o; bit st, b1, ba, va, to;
    bits_q[0] = 1'b1; bits_q[1] = 1'b1;
    run_window(2, 1'b0, 16'd100, 6, 0, -1, -1, rd, rp, vc, o, st, b1, ba, va, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL late_timeout got=no_handshake exp=handshake"); end
    n_tests++; if (rd != 6) begin n_fail++; $display("FAIL late_ready_cycle got=%0d exp=6", rd); end
    n_tests++; if (rp != 1) begin n_fail++; $display("FAIL late_ready_pulses got=%0d exp=1", rp); end
    n_tests++; if (vc != 7) begin n_fail++; $display("FAIL late_valid_cycle got=%0d exp=7", vc); end
    n_tests++; if (o !== 16'd102) begin n_fail++; $display("FAIL late_psum got=%h exp=0066", o); end
  endtask

  task automatic test_overflow;
    int rd, rp, vc; logic [15:0] o; bit st, b1, ba, va, to;
    logic [15:0] exp_pos, exp_neg;
`ifdef MUL_ACCUM_SAT_EN
    exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
    exp_pos = 16'h8000; exp_neg = 16'h7FFF;
`endif
    bits_q[0] = 1'b1;
    run_window(1, 1'b0, 16'h7FFF, 0, 0, -1, -1, rd, rp, vc, o, st, b1, ba, va, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL ovf_timeout got=no_handshake exp=handshake"); end
    n_tests++; if (rd != 1) begin n_fail++; $display("FAIL ovf_n1_ready_cycle got=%0d exp=1", rd); end
    n_tests++; if (vc != 2) begin n_fail++; $display("FAIL ovf_n1_valid_cycle got=%0d exp=2", vc); end
    n_tests++; if (o !== exp_pos) begin n_fail++; $display("FAIL ovf_pos_psum got=%h exp=%h", o, exp_pos); end
    run_window(1, 1'b1, 16'h8000, 0, 0, -1, -1, rd, rp, vc, o, st, b1, ba, va, to);
    n_tests++; if (o !== exp_neg) begin n_fail++; $display("FAIL ovf_neg_psum got=%h exp=%h", o, exp_neg); end
  endtask

  task automatic test_random;
    int rd, rp, vc; logic [15:0] o; bit st, b1, ba, va, to;
    int n, pv, rdy, st1, exp_rd;
    logic [15:0] ps, ex;
    bit sg;
    for (int k = 0; k < 25; k++) begin
      n   = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) bits_q[i] = 1'($urandom);
      sg  = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       ps = 16'h7FF0 + 16'($urandom_range(0, 15));
        1:       ps = 16'h8000 + 16'($urandom_range(0, 15));
        default: ps = 16'($urandom);
      endcase
      pv  = $urandom_range(0, n + 3);
      rdy = $urandom_range(0, 50);
      st1 = $urandom_range(1, n);
      exp_rd = (pv > n) ? pv : n;
      ex  = model(count_ones(n), sg, ps);
      run_window(n, sg, ps, pv, rdy, st1, -1, rd, rp, vc, o, st, b1, ba, va, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL rnd%0d_timeout got=no_handshake exp=handshake", k); end
      n_tests++; if (rd != exp_rd) begin n_fail++; $display("FAIL rnd%0d_ready_cycle got=%0d exp=%0d", k, rd, exp_rd); end
      n_tests++; if (vc != exp_rd + 1) begin n_fail++; $display("FAIL rnd%0d_valid_cycle got=%0d exp=%0d", k, vc, exp_rd + 1); end
      n_tests++; if (o !== ex) begin n_fail++; $display("FAIL rnd%0d_psum got=%h exp=%h", k, o, ex); end
      n_tests++; if (st !== 1'b1 || rp != 1) begin n_fail++; $display("FAIL rnd%0d_hold got=stable%0b/pulses%0d exp=stable1/pulses1", k, st, rp); end
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_window;
    test_basic;
    test_neg_n0;
    test_backpressure;
    test_late_psum;
    test_overflow;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
